// File: rtl/irq_pkg.sv
// Shared types and helpers for the external-interrupt arbiter.
package irq_pkg;

    // Largest supported number of interrupt sources.
    localparam int MAX_SRC = 31;

    // Claim-tracking FSM states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Claim ID width: IDs run 1..n with 0 reserved for "none".
    function automatic int irq_id_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/irq_src_cell.sv
// Per-source front end: synchroniser, delay flop, rising-edge detect and
// the pending flop. Edge-mode pending is sticky until the top clears it on
// acknowledge; level-mode pending simply follows the synchronised line.
module irq_src_cell
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic src,
    input  logic edge_mode,
    input  logic clr,
    output logic pend
);

    logic s_s;
    logic s_d_r;
    logic rise_s;
    logic pend_r;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s_s = src;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_r;

            // Shift the raw line through the synchroniser chain.
            always_ff @(posedge clk_i) begin
                if (reset_i) begin
                    sync_r <= '0;
                end else begin
                    for (int j = SYNC_STAGES - 1; j > 0; j--) begin
                        sync_r[j] <= sync_r[j-1];
                    end
                    sync_r[0] <= src;
                end
            end

            assign s_s = sync_r[SYNC_STAGES-1];
        end
    endgenerate

    // One-cycle delayed copy of the synchronised line for edge detection.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s_d_r <= 1'b0;
        end else begin
            s_d_r <= s_s;
        end
    end

    assign rise_s = s_s & ~s_d_r;

    // Pending flop: a new edge beats a simultaneous clear so it is not lost.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_r <= 1'b0;
        end else if (edge_mode) begin
            if (rise_s) begin
                pend_r <= 1'b1;
            end else if (clr) begin
                pend_r <= 1'b0;
            end else begin
                pend_r <= pend_r;
            end
        end else begin
            pend_r <= s_s;
        end
    end

    assign pend = pend_r;

endmodule

// File: rtl/irq_arbiter.sv
// Multi-source external-interrupt arbiter. Latches requests per source,
// picks the lowest-index enabled pending source, presents it to the core
// as meip_o/claim_id_o and tracks the claim through ack and end-of-interrupt.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ID_W        = irq_id_w(NUM_SRC)
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic [NUM_SRC-1:0] enable_i,
    input  logic [NUM_SRC-1:0] edge_mode_i,
    output logic               meip_o,
    output logic [ID_W-1:0]    claim_id_o,
    input  logic               irq_ack_i,
    input  logic               eoi_i,
    output logic [NUM_SRC-1:0] pending_o
);

    irq_state_t        state_r;
    irq_state_t        state_nxt_s;
    logic              meip_r;
    logic              meip_nxt_s;
    logic [ID_W-1:0]   claim_id_r;
    logic [ID_W-1:0]   claim_id_nxt_s;

    logic [NUM_SRC-1:0] pend_s;
    logic [NUM_SRC-1:0] clr_s;
    logic [NUM_SRC-1:0] insvc_mask_s;
    logic [NUM_SRC-1:0] elig_s;
    logic [ID_W-1:0]    winner_id_s;

    // Per-source front ends.
    generate
        for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
            irq_src_cell #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_cell (
                .clk_i     (clk_i),
                .reset_i   (reset_i),
                .src       (src_i[g]),
                .edge_mode (edge_mode_i[g]),
                .clr       (clr_s[g]),
                .pend      (pend_s[g])
            );
        end
    endgenerate

    // Decode the current claim into an ack-clear strobe and in-service mask.
    always_comb begin
        clr_s        = '0;
        insvc_mask_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            clr_s[i]        = (state_r == REQ) & irq_ack_i &
                              (claim_id_r == ID_W'(i + 1));
            insvc_mask_s[i] = (state_r == SERVICE) &
                              (claim_id_r == ID_W'(i + 1));
        end
    end

    assign elig_s = pend_s & enable_i & ~insvc_mask_s;

    // Fixed-priority encoder: scanning downwards leaves the lowest index.
    always_comb begin
        winner_id_s = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            winner_id_s = elig_s[i] ? ID_W'(i + 1) : winner_id_s;
        end
    end

    // Claim FSM next-state and registered-output values. Once raised, the
    // claim is frozen until ack even if a better source shows up.
    always_comb begin
        state_nxt_s    = state_r;
        meip_nxt_s     = meip_r;
        claim_id_nxt_s = claim_id_r;
        case (state_r)
            IDLE: begin
                if (|elig_s) begin
                    claim_id_nxt_s = winner_id_s;
                    meip_nxt_s     = 1'b1;
                    state_nxt_s    = REQ;
                end else begin
                    claim_id_nxt_s = '0;
                    meip_nxt_s     = 1'b0;
                end
            end
            REQ: begin
                if (irq_ack_i) begin
                    meip_nxt_s  = 1'b0;
                    state_nxt_s = SERVICE;
                end else begin
                    meip_nxt_s  = 1'b1;
                end
            end
            SERVICE: begin
                if (eoi_i) begin
                    claim_id_nxt_s = '0;
                    state_nxt_s    = IDLE;
                end else begin
                    meip_nxt_s     = 1'b0;
                end
            end
            default: begin
                state_nxt_s    = IDLE;
                meip_nxt_s     = 1'b0;
                claim_id_nxt_s = '0;
            end
        endcase
    end

    // State, request and claim registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            meip_r     <= 1'b0;
            claim_id_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            meip_r     <= meip_nxt_s;
            claim_id_r <= claim_id_nxt_s;
        end
    end

    assign meip_o     = meip_r;
    assign claim_id_o = claim_id_r;
    assign pending_o  = pend_s;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed bench for irq_arbiter (NUM_SRC=8, SYNC_STAGES=2).
module tb_irq_arbiter;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic [7:0] src_i;
    logic [7:0] enable_i;
    logic [7:0] edge_mode_i;
    logic       meip_o;
    logic [3:0] claim_id_o;
    logic       irq_ack_i;
    logic       eoi_i;
    logic [7:0] pending_o;

    int total = 0;
    int bad   = 0;

    irq_arbiter #(
        .NUM_SRC     (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .src_i       (src_i),
        .enable_i    (enable_i),
        .edge_mode_i (edge_mode_i),
        .meip_o      (meip_o),
        .claim_id_o  (claim_id_o),
        .irq_ack_i   (irq_ack_i),
        .eoi_i       (eoi_i),
        .pending_o   (pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_i     = 1'b1;
        src_i       = 8'hFF;
        enable_i    = 8'hFF;
        edge_mode_i = 8'h00;
        irq_ack_i   = 1'b0;
        eoi_i       = 1'b0;

        // Reset held with all sources high
        tick(3);
        chk("rst_meip", 32'(meip_o), 32'd0);
        chk("rst_claim", 32'(claim_id_o), 32'd0);
        chk("rst_pend", 32'(pending_o), 32'd0);

        // Release: level sources present with ID 1 three cycles later
        reset_i = 1'b0;
        tick(1);
        chk("rel_meip_k", 32'(meip_o), 32'd0);
        tick(1);
        tick(1);
        chk("rel_pend_k2", 32'(pending_o), 32'hFF);
        chk("rel_meip_k2", 32'(meip_o), 32'd0);
        tick(1);
        chk("rel_meip_k3", 32'(meip_o), 32'd1);
        chk("rel_claim_k3", 32'(claim_id_o), 32'd1);

        // Back to a clean, all-edge configuration
        reset_i     = 1'b1;
        src_i       = 8'h00;
        edge_mode_i = 8'hFF;
        tick(2);
        reset_i = 1'b0;
        tick(3);
        chk("clean_pend", 32'(pending_o), 32'd0);

        // Ack in IDLE is ignored
        irq_ack_i = 1'b1;
        tick(1);
        irq_ack_i = 1'b0;
        tick(1);
        chk("idle_ack_meip", 32'(meip_o), 32'd0);
        chk("idle_ack_claim", 32'(claim_id_o), 32'd0);

        // Single edge pulse on source 3
        src_i = 8'h08;
        tick(1);
        src_i = 8'h00;
        tick(2);
        chk("e3_pend", 32'(pending_o), 32'h08);
        chk("e3_meip_early", 32'(meip_o), 32'd0);
        tick(1);
        chk("e3_meip", 32'(meip_o), 32'd1);
        chk("e3_claim", 32'(claim_id_o), 32'd4);
        irq_ack_i = 1'b1;
        tick(1);
        irq_ack_i = 1'b0;
        chk("e3_ack_meip", 32'(meip_o), 32'd0);
        chk("e3_ack_pend", 32'(pending_o), 32'h00);
        chk("e3_svc_claim", 32'(claim_id_o), 32'd4);
        tick(2);
        chk("e3_svc_hold", 32'(claim_id_o), 32'd4);
        chk("e3_svc_meip", 32'(meip_o), 32'd0);
        eoi_i = 1'b1;
        tick(1);
        eoi_i = 1'b0;
        chk("e3_eoi_claim", 32'(claim_id_o), 32'd0);

        // Priority and freeze: source 5 then source 1
        src_i = 8'h20;
        tick(1);
        src_i = 8'h02;
        tick(1);
        src_i = 8'h00;
        tick(2);
        chk("pf_meip", 32'(meip_o), 32'd1);
        chk("pf_claim", 32'(claim_id_o), 32'd6);
        chk("pf_pend", 32'(pending_o), 32'h22);
        tick(2);
        chk("pf_frozen", 32'(claim_id_o), 32'd6);
        irq_ack_i = 1'b1;
        tick(1);
        irq_ack_i = 1'b0;
        chk("pf_ack_meip", 32'(meip_o), 32'd0);
        chk("pf_ack_pend", 32'(pending_o), 32'h02);
        eoi_i = 1'b1;
        tick(1);
        eoi_i = 1'b0;
        chk("pf_gap_meip", 32'(meip_o), 32'd0);
        chk("pf_gap_claim", 32'(claim_id_o), 32'd0);
        tick(1);
        chk("pf_next_meip", 32'(meip_o), 32'd1);
        chk("pf_next_claim", 32'(claim_id_o), 32'd2);
        irq_ack_i = 1'b1;
        tick(1);
        irq_ack_i = 1'b0;
        chk("pf2_ack_pend", 32'(pending_o), 32'h00);
        eoi_i = 1'b1;
        tick(1);
        eoi_i = 1'b0;
        chk("pf2_eoi_claim", 32'(claim_id_o), 32'd0);

        // Mask: source 2 disabled latches but does not present
        enable_i = 8'hFB;
        src_i    = 8'h04;
        tick(1);
        src_i = 8'h00;
        tick(2);
        chk("mask_pend", 32'(pending_o), 32'h04);
        tick(3);
        chk("mask_meip", 32'(meip_o), 32'd0);
        enable_i = 8'hFF;
        tick(1);
        chk("unmask_meip", 32'(meip_o), 32'd1);
        chk("unmask_claim", 32'(claim_id_o), 32'd3);
        irq_ack_i = 1'b1;
        tick(1);
        irq_ack_i = 1'b0;
        eoi_i = 1'b1;
        tick(1);
        eoi_i = 1'b0;
        chk("mask_eoi_claim", 32'(claim_id_o), 32'd0);

        // Second edge on the claimed source in the ack cycle keeps pending
        src_i = 8'h10;
        tick(1);
        src_i = 8'h00;
        tick(1);
        src_i = 8'h10;
        tick(1);
        src_i = 8'h00;
        tick(1);
        chk("re_meip", 32'(meip_o), 32'd1);
        chk("re_claim", 32'(claim_id_o), 32'd5);
        irq_ack_i = 1'b1;
        tick(1);
        irq_ack_i = 1'b0;
        chk("re_ack_meip", 32'(meip_o), 32'd0);
        chk("re_ack_pend", 32'(pending_o), 32'h10);

        // Reset during SERVICE drops the claim and the pending edge
        reset_i = 1'b1;
        tick(1);
        chk("svc_rst_meip", 32'(meip_o), 32'd0);
        chk("svc_rst_claim", 32'(claim_id_o), 32'd0);
        chk("svc_rst_pend", 32'(pending_o), 32'd0);
        reset_i = 1'b0;
        tick(3);
        chk("svc_rst_idle", 32'(meip_o), 32'd0);

        // Simultaneous ack and eoi in REQ: ack taken, eoi ignored
        src_i = 8'h80;
        tick(1);
        src_i = 8'h00;
        tick(3);
        chk("ae_claim", 32'(claim_id_o), 32'd8);
        irq_ack_i = 1'b1;
        eoi_i     = 1'b1;
        tick(1);
        irq_ack_i = 1'b0;
        eoi_i     = 1'b0;
        chk("ae_meip", 32'(meip_o), 32'd0);
        chk("ae_claim_held", 32'(claim_id_o), 32'd8);
        eoi_i = 1'b1;
        tick(1);
        eoi_i = 1'b0;
        chk("ae_eoi_claim", 32'(claim_id_o), 32'd0);

        // Level re-trigger on source 0
        edge_mode_i = 8'hFE;
        src_i       = 8'h01;
        tick(3);
        chk("lv_meip_early", 32'(meip_o), 32'd0);
        tick(1);
        chk("lv_meip", 32'(meip_o), 32'd1);
        chk("lv_claim", 32'(claim_id_o), 32'd1);
        irq_ack_i = 1'b1;
        tick(1);
        irq_ack_i = 1'b0;
        chk("lv_ack_pend", 32'(pending_o), 32'h01);
        eoi_i = 1'b1;
        tick(1);
        eoi_i = 1'b0;
        chk("lv_eoi_meip", 32'(meip_o), 32'd0);
        tick(1);
        chk("lv_rereq_meip", 32'(meip_o), 32'd1);
        chk("lv_rereq_claim", 32'(claim_id_o), 32'd1);

        // Drop the level: no further request
        src_i     = 8'h00;
        irq_ack_i = 1'b1;
        tick(1);
        irq_ack_i = 1'b0;
        tick(2);
        chk("lv_drop_pend", 32'(pending_o), 32'h00);
        eoi_i = 1'b1;
        tick(1);
        eoi_i = 1'b0;
        tick(3);
        chk("lv_drop_meip", 32'(meip_o), 32'd0);
        chk("lv_drop_claim", 32'(claim_id_o), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
